edge_count_window_monitor: RTL and testbench



---
 rtl/edge_count_window_monitor_pkg.sv | 11 +
 rtl/edge_window_queue.sv | 60 ++++++
 rtl/edge_count_window_monitor.sv | 85 ++++++++
 tb/tb_edge_count_window_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/edge_count_window_monitor_pkg.sv
// Shared types and constants for the windowed edge-count monitor.
package edge_count_window_monitor_pkg;

  localparam int unsigned COUNT_W = 8;

  typedef struct packed {
    logic [COUNT_W-1:0] delta;
    logic               over;
  } rec_t;

endpackage

// File: rtl/edge_window_queue.sv
// Small power-of-two FIFO of window records with synchronous reset/flush.
// A push while full is accepted only when a pop happens in the same cycle.
module edge_window_queue
  import edge_count_window_monitor_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic flush_i,
  input  logic enq_valid_i,
  input  rec_t enq_data_i,
  input  logic deq_ready_i,
  output rec_t deq_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  rec_t            mem_q [Depth];
  logic            do_enq, do_deq;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (PtrW + 1)'(Depth));
  assign deq_data_o = mem_q[rptr_q];

  assign do_deq = deq_ready_i && !empty_o;
  assign do_enq = enq_valid_i && (!full_o || do_deq);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_enq) wptr_d = wptr_q + PtrW'(1);
    if (do_deq) rptr_d = rptr_q + PtrW'(1);
    if (do_enq && !do_deq) cnt_d = cnt_q + (PtrW + 1)'(1);
    if (!do_enq && do_deq) cnt_d = cnt_q - (PtrW + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_enq) mem_q[wptr_q] <= enq_data_i;
  end

endmodule

// File: rtl/edge_count_window_monitor.sv
// Snapshots the upstream transition count every WINDOW enabled cycles and
// queues {delta, over} records for a val/rdy consumer.
module edge_count_window_monitor
  import edge_count_window_monitor_pkg::*;
#(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned QDEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic [COUNT_W-1:0] count,
  input  logic [COUNT_W-1:0] thresh,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [COUNT_W-1:0] out_delta,
  output logic               out_over,
  output logic [7:0]         drop_count
);

  localparam int unsigned WcntW = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  logic [WcntW-1:0]   wcnt_q, wcnt_d;
  logic [COUNT_W-1:0] snap_q, snap_d;
  logic [7:0]         drop_q, drop_d;
  logic               last, sample, q_full, q_empty, drop;
  rec_t               new_rec, head_rec;

  assign last   = (wcnt_q == WcntW'(WINDOW - 1));
  assign sample = en && last && !clear;

  assign new_rec.delta = count - snap_q;
  assign new_rec.over  = (new_rec.delta >= thresh);

  // A full queue only takes the record if the head leaves this same cycle.
  assign drop = sample && q_full && !out_rdy;

  always_comb begin
    wcnt_d = wcnt_q;
    snap_d = snap_q;
    drop_d = drop_q;
    if (clear) begin
      wcnt_d = '0;
      snap_d = '0;
      drop_d = '0;
    end else begin
      if (en) wcnt_d = last ? '0 : wcnt_q + WcntW'(1);
      if (sample) snap_d = count;
      if (drop && drop_q != 8'hff) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
      snap_q <= '0;
      drop_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      snap_q <= snap_d;
      drop_q <= drop_d;
    end
  end

  edge_window_queue #(
    .Depth (QDEPTH)
  ) u_queue (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (clear),
    .enq_valid_i (sample),
    .enq_data_i  (new_rec),
    .deq_ready_i (out_rdy),
    .deq_data_o  (head_rec),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  assign out_val    = !q_empty;
  assign out_delta  = head_rec.delta;
  assign out_over   = head_rec.over;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_edge_count_window_monitor.sv
// Directed bench with a record scoreboard for edge_count_window_monitor (WINDOW=4, QDEPTH=2).
module tb_edge_count_window_monitor;
  import edge_count_window_monitor_pkg::*;

  localparam int unsigned Win = 4;
  localparam int unsigned Qd  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1, clear = 1'b0, en = 1'b0, out_rdy = 1'b0;
  logic [7:0] count = '0, thresh = '0;
  logic       out_val, out_over;
  logic [7:0] out_delta, drop_count;

  int checks = 0;
  int failures = 0;

  // Reference model state
  rec_t       exp_q [$];
  int         m_wcnt;
  logic [7:0] m_snap;
  logic [7:0] m_drop;

  edge_count_window_monitor #(
    .WINDOW (Win),
    .QDEPTH (Qd)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .en         (en),
    .count      (count),
    .thresh     (thresh),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_delta  (out_delta),
    .out_over   (out_over),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wcnt = 0;
    m_snap = '0;
    m_drop = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; en = 1'b0; out_rdy = 1'b0; count = '0; thresh = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_val", {8'd0, out_val}, 9'd0);
    chk("rst_drop", {1'b0, drop_count}, 9'd0);
  endtask

  // One clock cycle: drive, compare against scoreboard head, then advance the model.
  task automatic cyc(input logic e, input logic c, input logic [7:0] cnt,
                     input logic [7:0] th, input logic r);
    rec_t rec;
    bit   pop;
    en = e; clear = c; count = cnt; thresh = th; out_rdy = r;
    @(negedge clk);
    chk("out_val", {8'd0, out_val}, {8'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      chk("out_delta", {1'b0, out_delta}, {1'b0, exp_q[0].delta});
      chk("out_over", {8'd0, out_over}, {8'd0, exp_q[0].over});
    end
    chk("drop_count", {1'b0, drop_count}, {1'b0, m_drop});
    @(posedge clk);
    pop = (exp_q.size() > 0) && r;
    if (c) begin
      model_reset();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (e) begin
        if (m_wcnt == Win - 1) begin
          rec.delta = cnt - m_snap;
          rec.over  = (int'(rec.delta) >= int'(th));
          m_snap    = cnt;
          m_wcnt    = 0;
          if (exp_q.size() < Qd) exp_q.push_back(rec);
          else if (m_drop != 8'hff) m_drop = m_drop + 8'd1;
        end else begin
          m_wcnt++;
        end
      end
    end
    #1;
  endtask

  task automatic window(input logic [7:0] cnt, input logic [7:0] th, input logic r);
    for (int i = 0; i < Win; i++) cyc(1'b1, 1'b0, cnt, th, r);
  endtask

  task automatic expect_head(input string tag, input logic v, input logic [7:0] d,
                             input logic o);
    chk({tag, "_val"}, {8'd0, out_val}, {8'd0, v});
    if (v) begin
      chk({tag, "_delta"}, {1'b0, out_delta}, {1'b0, d});
      chk({tag, "_over"}, {8'd0, out_over}, {8'd0, o});
    end
  endtask

  initial begin
    model_reset();

    // Basic window: counts 0,3,7,10 give delta 10 >= 8
    do_reset();
    cyc(1'b1, 1'b0, 8'd0, 8'd8, 1'b1);
    cyc(1'b1, 1'b0, 8'd3, 8'd8, 1'b1);
    cyc(1'b1, 1'b0, 8'd7, 8'd8, 1'b1);
    cyc(1'b1, 1'b0, 8'd10, 8'd8, 1'b1);
    expect_head("basic", 1'b1, 8'd10, 1'b1);
    cyc(1'b1, 1'b0, 8'd10, 8'd8, 1'b1);
    expect_head("basic_drained", 1'b0, 8'd0, 1'b0);

    // Wrap-around: snap 250 -> count 4 gives delta 10 < 11
    do_reset();
    window(8'd250, 8'd0, 1'b1);
    expect_head("snap250", 1'b1, 8'd250, 1'b1);
    window(8'd4, 8'd11, 1'b1);
    expect_head("wrap", 1'b1, 8'd10, 1'b0);

    // Full queue with consumer stalled: third record is dropped
    do_reset();
    window(8'd1, 8'd0, 1'b0);
    window(8'd2, 8'd0, 1'b0);
    window(8'd3, 8'd0, 1'b0);
    expect_head("full", 1'b1, 8'd1, 1'b1);
    chk("full_drop", {1'b0, drop_count}, 9'd1);
    cyc(1'b0, 1'b0, 8'd3, 8'd0, 1'b1);
    expect_head("drain1", 1'b1, 8'd1, 1'b1);
    cyc(1'b0, 1'b0, 8'd3, 8'd0, 1'b1);
    expect_head("drain2", 1'b0, 8'd0, 1'b0);

    // en gating delays the sample by the gap length
    do_reset();
    cyc(1'b1, 1'b0, 8'd0, 8'd5, 1'b0);
    cyc(1'b1, 1'b0, 8'd2, 8'd5, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'd9, 8'd5, 1'b0);
    cyc(1'b1, 1'b0, 8'd9, 8'd5, 1'b0);
    expect_head("gate_pending", 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 8'd9, 8'd5, 1'b0);
    expect_head("gate", 1'b1, 8'd9, 1'b1);

    // Clear mid-window flushes the queue and restarts from 0
    do_reset();
    window(8'd6, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 8'd6, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 8'd6, 8'd0, 1'b0);
    cyc(1'b1, 1'b1, 8'd0, 8'd0, 1'b0);
    expect_head("clear", 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 8'd1, 8'd6, 1'b0);
    cyc(1'b1, 1'b0, 8'd2, 8'd6, 1'b0);
    cyc(1'b1, 1'b0, 8'd3, 8'd6, 1'b0);
    expect_head("clear_pending", 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 8'd5, 8'd6, 1'b0);
    expect_head("clear_sample", 1'b1, 8'd5, 1'b0);

    // Full queue with a dequeue in the sample cycle: no drop
    do_reset();
    window(8'd1, 8'd1, 1'b0);
    window(8'd2, 8'd1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'd5, 8'd1, 1'b0);
    cyc(1'b1, 1'b0, 8'd5, 8'd1, 1'b1);
    expect_head("simul", 1'b1, 8'd1, 1'b1);
    chk("simul_drop", {1'b0, drop_count}, 9'd0);
    cyc(1'b0, 1'b0, 8'd5, 8'd1, 1'b1);
    expect_head("simul_new", 1'b1, 8'd3, 1'b1);
    cyc(1'b0, 1'b0, 8'd5, 8'd1, 1'b1);
    cyc(1'b0, 1'b0, 8'd5, 8'd1, 1'b1);
    expect_head("simul_empty", 1'b0, 8'd0, 1'b0);

    // drop_count saturates at 255
    do_reset();
    for (int i = 0; i < 262; i++) window(8'(i + 1), 8'd0, 1'b0);
    chk("drop_sat", {1'b0, drop_count}, 9'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
